// File: rtl/ds_tx_scheduler.sv
// Per-character transmit scheduler for a DS-link encoder: picks FCT, packet
// data/EOP (round-robin, packet-locked, credit-gated) or NULL for each slot.
module ds_tx_scheduler #(
    parameter int N_REQ          = 2,
    parameter int CREDIT_PER_FCT = 8,
    parameter int MAX_CREDIT     = 56,
    parameter int MAX_FCT_PEND   = 7
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 link_run,
    input  logic                 fct_rx,
    input  logic                 rx_space,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [N_REQ-1:0]     req_eop,
    input  logic [8*N_REQ-1:0]   req_data,
    output logic [N_REQ-1:0]     req_ready,
    output logic                 char_valid,
    input  logic                 char_ready,
    output logic [1:0]           char_type,
    output logic [7:0]           char_data,
    output logic [5:0]           tx_credit,
    output logic [2:0]           fct_pend,
    output logic [2:0]           grant_idx,
    output logic                 grant_lock,
    output logic                 credit_err
);

    typedef enum logic [1:0] {
        CT_DATA = 2'b00,
        CT_FCT  = 2'b01,
        CT_EOP  = 2'b10,
        CT_NULL = 2'b11
    } char_t;

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    state_t      state;
    logic [2:0]  rr_ptr;

    logic        slot_free;
    logic        send_fct;
    logic        send_n;
    logic [7:0]  valid_pad;
    logic [7:0]  eop_pad;
    logic [63:0] data_pad;
    logic [7:0]  ready_pad;
    logic [2:0]  sel_idx;
    logic        sel_found;
    logic [3:0]  cand;
    logic [3:0]  rr_next;
    logic [6:0]  credit_sum;
    logic [3:0]  pend_sum;
    logic        credit_ovf;
    logic        pend_ovf;

    assign slot_free = link_run && (!char_valid || char_ready);

    // Requester vectors are padded to 8 so any 3-bit index is in range.
    always_comb begin
        valid_pad                 = '0;
        eop_pad                   = '0;
        data_pad                  = '0;
        valid_pad[N_REQ-1:0]      = req_valid;
        eop_pad[N_REQ-1:0]        = req_eop;
        data_pad[8*N_REQ-1:0]     = req_data;
    end

    always_comb begin
        sel_idx   = '0;
        sel_found = 1'b0;
        cand      = '0;
        if (state == LOCKED) begin
            sel_idx   = grant_idx;
            sel_found = valid_pad[grant_idx];
        end else begin
            for (int unsigned k = 0; k < N_REQ; k++) begin
                cand = {1'b0, rr_ptr} + 4'(k);
                if (cand >= 4'(N_REQ))
                    cand = cand - 4'(N_REQ);
                if (!sel_found && valid_pad[cand[2:0]]) begin
                    sel_found = 1'b1;
                    sel_idx   = cand[2:0];
                end
            end
        end
    end

    always_comb begin
        send_fct  = slot_free && (fct_pend != '0);
        send_n    = slot_free && (fct_pend == '0) && (tx_credit != '0) && sel_found;
        ready_pad = '0;
        if (send_n)
            ready_pad[sel_idx] = 1'b1;
        req_ready = ready_pad[N_REQ-1:0];

        rr_next = {1'b0, sel_idx} + 4'd1;
        if (rr_next >= 4'(N_REQ))
            rr_next = '0;

        credit_sum = {1'b0, tx_credit} + (fct_rx ? 7'(CREDIT_PER_FCT) : 7'd0)
                     - (send_n ? 7'd1 : 7'd0);
        credit_ovf = credit_sum > 7'(MAX_CREDIT);
        pend_sum   = {1'b0, fct_pend} + {3'b000, rx_space} - {3'b000, send_fct};
        pend_ovf   = pend_sum > 4'(MAX_FCT_PEND);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            char_valid <= 1'b0;
            char_type  <= '0;
            char_data  <= '0;
            tx_credit  <= '0;
            fct_pend   <= '0;
            grant_idx  <= '0;
            grant_lock <= 1'b0;
            credit_err <= 1'b0;
        end else if (!link_run) begin
            // Link down drops any held character and all flow-control state.
            state      <= IDLE;
            char_valid <= 1'b0;
            char_type  <= '0;
            char_data  <= '0;
            tx_credit  <= '0;
            fct_pend   <= '0;
            grant_lock <= 1'b0;
        end else begin
            tx_credit <= credit_ovf ? 6'(MAX_CREDIT) : credit_sum[5:0];
            fct_pend  <= pend_ovf ? 3'(MAX_FCT_PEND) : pend_sum[2:0];
            if (credit_ovf || pend_ovf)
                credit_err <= 1'b1;

            if (slot_free) begin
                char_valid <= 1'b1;
                char_data  <= '0;
                if (send_fct) begin
                    char_type <= CT_FCT;
                end else if (send_n) begin
                    if (eop_pad[sel_idx]) begin
                        char_type <= CT_EOP;
                    end else begin
                        char_type <= CT_DATA;
                        char_data <= data_pad[{sel_idx, 3'b000} +: 8];
                    end
                end else begin
                    char_type <= CT_NULL;
                end
            end

            if (send_n) begin
                if (eop_pad[sel_idx]) begin
                    state      <= IDLE;
                    grant_lock <= 1'b0;
                    rr_ptr     <= rr_next[2:0];
                end else begin
                    state      <= LOCKED;
                    grant_lock <= 1'b1;
                    grant_idx  <= sel_idx;
                end
            end
        end
    end

endmodule

// File: tb/tb_ds_tx_scheduler.sv
// Bench for ds_tx_scheduler: directed scenarios plus randomized traffic, all
// checked every cycle against a behavioural model of the slot/credit rules.
module tb_ds_tx_scheduler;

    localparam int N_REQ = 2;
    localparam int CPF   = 8;
    localparam int MAXC  = 56;
    localparam int MAXP  = 7;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                link_run = 1'b0;
    logic                fct_rx = 1'b0;
    logic                rx_space = 1'b0;
    logic                char_ready = 1'b1;
    logic [N_REQ-1:0]    req_valid = '0;
    logic [N_REQ-1:0]    req_eop = '0;
    logic [8*N_REQ-1:0]  req_data = '0;
    logic [N_REQ-1:0]    req_ready;
    logic                char_valid;
    logic [1:0]          char_type;
    logic [7:0]          char_data;
    logic [5:0]          tx_credit;
    logic [2:0]          fct_pend;
    logic [2:0]          grant_idx;
    logic                grant_lock;
    logic                credit_err;

    ds_tx_scheduler #(
        .N_REQ(N_REQ), .CREDIT_PER_FCT(CPF), .MAX_CREDIT(MAXC), .MAX_FCT_PEND(MAXP)
    ) dut (
        .clk(clk), .rst(rst), .link_run(link_run), .fct_rx(fct_rx), .rx_space(rx_space),
        .req_valid(req_valid), .req_eop(req_eop), .req_data(req_data), .req_ready(req_ready),
        .char_valid(char_valid), .char_ready(char_ready), .char_type(char_type),
        .char_data(char_data), .tx_credit(tx_credit), .fct_pend(fct_pend),
        .grant_idx(grant_idx), .grant_lock(grant_lock), .credit_err(credit_err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int gap_pct = 0;
    int null_cnt = 0;
    logic [8:0] q0[$];
    logic [8:0] q1[$];
    logic [9:0] nlog[$];
    logic [9:0] expq[$];

    // Model state: what the registered outputs must hold this cycle.
    int m_valid, m_type, m_data, m_credit, m_pend, m_lock, m_idx, m_err, m_rr;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin : model
        int sel, j, c, p;
        bit free, sfct, sn;
        logic [N_REQ-1:0] exp_rdy;
        if (rst) begin
            m_valid = 0; m_type = 0; m_data = 0; m_credit = 0; m_pend = 0;
            m_lock = 0; m_idx = 0; m_err = 0; m_rr = 0;
        end
        check("char_valid", char_valid, m_valid);
        check("char_type", char_type, m_type);
        check("char_data", char_data, m_data);
        check("tx_credit", tx_credit, m_credit);
        check("fct_pend", fct_pend, m_pend);
        check("grant_lock", grant_lock, m_lock);
        check("credit_err", credit_err, m_err);
        if (m_lock != 0)
            check("grant_idx", grant_idx, m_idx);

        free = !rst && link_run && (m_valid == 0 || char_ready);
        sel = -1;
        if (m_lock != 0) sel = m_idx;
        else
            for (int k = 0; k < N_REQ; k++) begin
                j = (m_rr + k) % N_REQ;
                if (sel < 0 && req_valid[j]) sel = j;
            end
        sfct = free && m_pend > 0;
        sn = free && !sfct && m_credit > 0 && sel >= 0 && req_valid[sel];
        exp_rdy = '0;
        if (sn) exp_rdy[sel] = 1'b1;
        check("req_ready", req_ready, exp_rdy);

        if (!rst && char_valid && char_ready) begin
            if (char_type == 2'b11) null_cnt++;
            else nlog.push_back({char_type, char_data});
        end
        if (req_ready[0] && q0.size() > 0) void'(q0.pop_front());
        if (req_ready[1] && q1.size() > 0) void'(q1.pop_front());

        if (!rst) begin
            if (!link_run) begin
                m_valid = 0; m_type = 0; m_data = 0; m_credit = 0; m_pend = 0; m_lock = 0;
            end else begin
                c = m_credit + (fct_rx ? CPF : 0) - (sn ? 1 : 0);
                if (c > MAXC) begin c = MAXC; m_err = 1; end
                p = m_pend + int'(rx_space) - int'(sfct);
                if (p > MAXP) begin p = MAXP; m_err = 1; end
                if (free) begin
                    m_valid = 1;
                    m_data = 0;
                    if (sfct) m_type = 1;
                    else if (sn && req_eop[sel]) m_type = 2;
                    else if (sn) begin m_type = 0; m_data = int'(req_data[8*sel +: 8]); end
                    else m_type = 3;
                end
                if (sn) begin
                    if (req_eop[sel]) begin m_lock = 0; m_rr = (sel + 1) % N_REQ; end
                    else begin m_lock = 1; m_idx = sel; end
                end
                m_credit = c;
                m_pend = p;
            end
        end
    end

    // Packet sources: present queue heads, optionally with idle gaps.
    always @(posedge clk) begin
        #1;
        req_valid = '0; req_eop = '0; req_data = '0;
        if (q0.size() > 0 && $urandom_range(99) >= gap_pct) begin
            req_valid[0] = 1'b1; req_eop[0] = q0[0][8]; req_data[7:0] = q0[0][7:0];
        end
        if (q1.size() > 0 && $urandom_range(99) >= gap_pct) begin
            req_valid[1] = 1'b1; req_eop[1] = q1[0][8]; req_data[15:8] = q1[0][7:0];
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_fct(input int n);
        fct_rx = 1'b1; cycles(n); fct_rx = 1'b0;
    endtask

    task automatic pulse_space(input int n);
        rx_space = 1'b1; cycles(n); rx_space = 1'b0;
    endtask

    task automatic clear_log();
        nlog.delete(); null_cnt = 0; expq.delete();
    endtask

    task automatic drain(input int maxc);
        int k = 0;
        while ((q0.size() + q1.size()) > 0 && k < maxc) begin cycles(1); k++; end
        check("drain_timeout", q0.size() + q1.size(), 0);
        cycles(3);
    endtask

    task automatic check_log(input string name);
        check({name, "_len"}, nlog.size(), expq.size());
        for (int i = 0; i < expq.size() && i < nlog.size(); i++)
            check(name, int'(nlog[i]), int'(expq[i]));
    endtask

    task automatic link_cycle();
        link_run = 1'b0; cycles(2); link_run = 1'b1; cycles(1);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : main
        int k;
        bit found;
        cycles(2);
        rst = 1'b0;
        check("rst_credit", tx_credit, 0);
        check("rst_valid", char_valid, 0);
        check("rst_gidx", grant_idx, 0);

        // 1: idle link sends NULLs only
        clear_log(); link_run = 1'b1; cycles(10);
        check("t1_nonnull", nlog.size(), 0);
        check("t1_nulls", int'(null_cnt >= 8), 1);
        check("t1_pend", fct_pend, 0);

        // 2: FCTs first, then the packet in order
        clear_log();
        pulse_space(2); pulse_fct(1);
        q0.push_back(9'h000); q0.push_back(9'h055); q0.push_back(9'h0C3); q0.push_back(9'h100);
        drain(50);
        expq = '{10'h100, 10'h100, 10'h000, 10'h055, 10'h0C3, 10'h200};
        check_log("t2_seq");
        check("t2_credit", tx_credit, 4);

        // 3: credit stall mid-packet
        link_cycle(); pulse_fct(1); clear_log();
        for (int i = 0; i < 10; i++) q0.push_back(9'(3 * i + 1));
        q0.push_back(9'h100);
        cycles(25);
        check("t3_sent", nlog.size(), 8);
        check("t3_lock", grant_lock, 1);
        check("t3_gidx", grant_idx, 0);
        check("t3_null", char_type, 3);
        pulse_fct(1); drain(40);
        for (int i = 0; i < 10; i++) expq.push_back(10'(3 * i + 1));
        expq.push_back(10'h200);
        check_log("t3_seq");
        check("t3_credit", tx_credit, 5);

        // 4: round-robin with packet lock
        link_cycle(); pulse_fct(7);
        check("t4_credit", tx_credit, 56);
        check("t4_err", credit_err, 0);
        clear_log();
        q1.push_back(9'h100); drain(20);
        q0 = '{9'h001, 9'h002, 9'h100, 9'h001, 9'h002, 9'h100};
        q1 = '{9'h011, 9'h012, 9'h100, 9'h011, 9'h012, 9'h100};
        drain(60);
        expq = '{10'h200, 10'h001, 10'h002, 10'h200, 10'h011, 10'h012, 10'h200,
                 10'h001, 10'h002, 10'h200, 10'h011, 10'h012, 10'h200};
        check_log("t4_seq");
        check("t4_credit_end", tx_credit, 43);

        // 5: overflow of credit and owed FCTs
        pulse_fct(8);
        check("t5_credit", tx_credit, 56);
        check("t5_err", credit_err, 1);
        char_ready = 1'b0; pulse_space(8);
        check("t5_pend", fct_pend, 7);
        char_ready = 1'b1; cycles(12);
        check("t5_pend_drained", fct_pend, 0);

        // 6: link drop mid-packet
        q0 = '{9'h089, 9'h09A, 9'h100};
        k = 0; found = 0;
        while (!found && k < 20) begin
            @(negedge clk);
            if (req_ready[0] && req_data[7:0] == 8'h89) found = 1;
            k++;
        end
        check("t6_accept", int'(found), 1);
        @(posedge clk); #1 link_run = 1'b0;
        @(posedge clk); @(negedge clk);
        check("t6_valid", char_valid, 0);
        check("t6_credit", tx_credit, 0);
        check("t6_lock", grant_lock, 0);
        q0.delete(); q1.delete();
        @(posedge clk); #1 link_run = 1'b1;
        clear_log(); cycles(10);
        check("t6_nonnull", nlog.size(), 0);
        check("t6_nulls", int'(null_cnt >= 8), 1);

        // Randomized traffic
        gap_pct = 20;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            fct_rx = ($urandom_range(99) < 8);
            rx_space = ($urandom_range(99) < 10);
            char_ready = ($urandom_range(99) < 80);
            if (link_run && $urandom_range(199) == 0) link_run = 1'b0;
            else if (!link_run && $urandom_range(3) == 0) link_run = 1'b1;
            if (q0.size() == 0 && $urandom_range(9) == 0) begin
                for (int i = $urandom_range(5); i > 0; i--) q0.push_back(9'($urandom_range(255)));
                q0.push_back(9'h100);
            end
            if (q1.size() == 0 && $urandom_range(9) == 0) begin
                for (int i = $urandom_range(5); i > 0; i--) q1.push_back(9'($urandom_range(255)));
                q1.push_back(9'h100);
            end
            cycles(1);
        end
        fct_rx = 1'b0; rx_space = 1'b0; char_ready = 1'b1;
        cycles(5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ds_tx_scheduler.md
Name: ds_tx_scheduler

Overview:
- Per-character transmit scheduler in front of the IEEE1355 DS-link character encoder inside node.
- Each character slot is filled with one of: a pending FCT, a data/EOP character from one of N_REQ packet sources (round-robin, packet-locked, gated by transmit credit), or NULL.
- Tracks the transmit credit granted by received FCTs and the FCTs owed to the far end.

Parameters:
N_REQ, 2, number of packet requesters (1..8)
CREDIT_PER_FCT, 8, N-chars (data or EOP) released per received FCT
MAX_CREDIT, 56, credit ceiling; exceeding it is a credit error
MAX_FCT_PEND, 7, maximum outstanding FCTs owed to far end

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
link_run  in  1  link in Run state; low = link down
fct_rx  in  1  pulse: FCT character received from far end
rx_space  in  1  pulse: local receive buffer freed CREDIT_PER_FCT slots, owe one FCT
req_valid  in  N_REQ  requester i has a character
req_eop  in  N_REQ  character of requester i is EOP (req_data ignored)
req_data  in  8*N_REQ  data byte of requester i, slice [8i+7:8i]
req_ready  out  N_REQ  character of requester i accepted this cycle
char_valid  out  1  character present to encoder
char_ready  in  1  encoder accepts character
char_type  out  2  00 data, 01 FCT, 10 EOP, 11 NULL
char_data  out  8  data byte (0 for non-data)
tx_credit  out  6  current transmit credit
fct_pend  out  3  FCTs owed
grant_idx  out  3  locked requester index (valid when grant_lock=1)
grant_lock  out  1  a packet is in progress
credit_err  out  1  sticky: credit overflow or FCT overflow

Behaviour:
- Reset: all outputs 0; state IDLE; rr pointer 0.
- Output register loads when link_run && (!char_valid || char_ready) ("slot free"). The char goes out 1 cycle after selection. req_ready[i] is asserted combinationally in the same cycle the slot loads requester i's character.
- Slot priority when slot free:
  1. fct_pend>0 -> FCT; fct_pend-1.
  2. Data/EOP from the selected requester if tx_credit>0 -> credit-1.
  3. Otherwise NULL.
  - char_valid stays 1 continuously while link_run=1.
- Requester selection:
  - IDLE: scan from rr pointer upward with wrap, taking the first req_valid. Accepting a non-EOP char -> LOCKED(i). Accepting an EOP from IDLE is a single-char packet and stays IDLE. After any EOP accept, rr pointer = i+1 mod N_REQ.
  - LOCKED(i): only requester i is served, even if it is not valid. Other requesters wait; insert NULL when i is idle. Accepting EOP of i -> IDLE.
- Credit:
  - fct_rx: credit += CREDIT_PER_FCT. A result above MAX_CREDIT saturates at MAX_CREDIT and sets credit_err.
  - Simultaneous fct_rx and N-char send: credit += CREDIT_PER_FCT-1.
- FCT owed:
  - rx_space: fct_pend+1. An increment beyond MAX_FCT_PEND holds the value and sets credit_err.
  - Simultaneous rx_space and FCT send: unchanged.
- link_run=0 (any time, including mid-packet): next cycle char_valid=0, req_ready=0, credit=0, fct_pend=0, state IDLE, rr pointer kept. fct_rx and rx_space are ignored while down. credit_err is cleared only by rst.
- A character in the output register when link_run falls is dropped. The packet owner must restart the packet itself; the block does not resend.
- Widths: credit 6-bit, fct_pend 3-bit, no wrap-around permitted (saturating as above).

Test Plan:
1. Reset then link_run=1, no inputs -> char_valid=1, char_type=11 every cycle char_ready=1; tx_credit=0, fct_pend=0.
2. rx_space x2, then fct_rx x1; req 0 sends 0x00,0x55,0xC3,EOP -> two FCT chars first, then 00,55,C3,EOP in order; tx_credit ends 4.
3. Credit stall: credit=8, requester 0 offers 10 data chars + EOP -> 8 data chars, then NULLs with grant_lock=1, grant_idx=0. Another fct_rx -> remaining 2 data + EOP, tx_credit=5.
4. Round-robin/lock: both requesters valid with 3-char packets (0x01,0x02,EOP / 0x11,0x12,EOP), credit 56 -> req 0 packet complete, then req 1 packet; no interleave. Repeat -> req 0 first again.
5. Overflow: 8 fct_rx pulses -> tx_credit=56, credit_err=1. 8 rx_space pulses -> fct_pend=7.
6. Drop link_run mid-packet after 0x89 accepted -> next cycle char_valid=0, tx_credit=0, grant_lock=0. Re-raise -> NULLs only until new credit.
